fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-aware arbiter that shares one FIFO write port between P_NUM_REQ valid/ready requesters.
- Sits in front of the FIFO write side, on the write clock.
- Locks the grant for a whole packet, ending on the requester's last beat or on a forced cut at P_MAX_BURST beats.
- Tags every output beat with the source ID so the read side can demultiplex.

Parameters:
P_NUM_REQ, 4, number of requesters (>=1)
P_WIDTH, 8, data word width
P_MAX_BURST, 16, max beats per grant before a forced cut (>=1, power of 2 not required)
P_ID_BITS, max(1,$clog2(P_NUM_REQ)), width of source ID (derived, not overridden)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
req_data  input  P_NUM_REQ*P_WIDTH  requester i data at bits [i*P_WIDTH +: P_WIDTH]
req_vld  input  P_NUM_REQ  requester valid
req_last  input  P_NUM_REQ  requester end-of-packet, qualified by req_vld
req_rdy  output  P_NUM_REQ  requester ready
out_data  output  P_WIDTH  data to FIFO write port
out_id  output  P_ID_BITS  index of granted requester
out_last  output  1  last beat of this grant (natural or forced)
out_vld  output  1  to FIFO wr_vld
out_rdy  input  1  from FIFO wr_rdy
grant  output  P_NUM_REQ  one-hot registered grant; 0 when idle
busy  output  1  high while in BURST

Behaviour:
- Reset (clk edge with rst=1): state IDLE, grant=0, priority pointer=0, beat counter=0. While in IDLE: req_rdy=0, out_vld=0, out_last=0, busy=0, out_id=0, out_data=0.
- rst has priority over every other event, including mid-burst. A partially transferred packet is abandoned; the arbiter does not track it.
- FSM IDLE:
  - If any req_vld, pick the first asserted index searching ptr, ptr+1, ... mod P_NUM_REQ.
  - Register grant (one-hot) and out_id, clear the counter, go to BURST.
  - If no req_vld, stay in IDLE.
- FSM BURST, with g = granted index:
  - Combinational passthrough: out_vld=req_vld[g], out_data=req_data[g], req_rdy[g]=out_rdy, all other req_rdy=0.
  - Handshake = out_vld & out_rdy. The counter increments only on a handshake.
  - force = (counter == P_MAX_BURST-1).
  - out_last = req_vld[g] & (req_last[g] | force).
  - On a handshake with out_last=1: go to IDLE, ptr <= (g+1) mod P_NUM_REQ, grant <= 0.
- Latency: req_vld rising in IDLE at edge n gives grant at edge n+1; the first beat can transfer in the cycle after edge n+1. One idle cycle between consecutive grants (2 cycles minimum per 1-beat packet).
- Grant lock: if req_vld[g] drops mid-packet, the grant is held with no timeout. Other requesters wait.
- Backpressure: out_rdy=0 holds the counter. Data stability is the requester's obligation.
- Forced cut: the packet continues on a later grant. Round-robin still advances, so with other requesters pending they are served first.
- A single requester re-wins every IDLE cycle.
- P_NUM_REQ=1: ptr is always 0, out_id=0.
- Counter width is $clog2(P_MAX_BURST)+1; it never wraps.

Test Plan:
- Requester 0 sends a 3-beat packet (0xA1, 0xA2, 0xA3, last on 3rd), out_rdy=1 -> grant=4'b0001 one cycle after req_vld; 3 consecutive beats with out_id=0; out_last only with 0xA3; then IDLE and busy=0.
- All 4 requesters hold 1-beat packets continuously -> grant order 0,1,2,3,0,1; one beat every 2 cycles; out_id sequence 0,1,2,3,0,1.
- P_MAX_BURST=16, requester 2 alone sends 20 beats with last on the 20th -> 16 beats, out_last on the 16th (forced); IDLE one cycle; regrant to 2; 4 beats, out_last on the 20th.
- Same as above, but requester 3 is also valid at the cut -> after the 16th beat requester 3 is granted next, then 2 resumes.
- out_rdy pattern 1,0,0,1,0,1 during a 3-beat packet from requester 1 -> req_rdy[1] mirrors out_rdy; exactly 3 handshakes; out_data unchanged across stalls; other req_rdy stay 0.
- rst pulsed for 1 cycle after beat 5 of an 8-beat packet from requester 3 -> next cycle grant=0, busy=0, req_rdy=0, out_vld=0. After release, with requesters 0 and 3 both valid -> requester 0 granted (ptr reset to 0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware arbiter sharing one FIFO write port between P_NUM_REQ
// valid/ready requesters; each output beat is tagged with its source ID.
module fifo_wr_arbiter #(
    parameter int unsigned  P_NUM_REQ   = 4,
    parameter int unsigned  P_WIDTH     = 8,
    parameter int unsigned  P_MAX_BURST = 16,
    localparam int unsigned P_ID_BITS   = (P_NUM_REQ > 1) ? $clog2(P_NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [P_NUM_REQ*P_WIDTH-1:0]   req_data,
    input  logic [P_NUM_REQ-1:0]           req_vld,
    input  logic [P_NUM_REQ-1:0]           req_last,
    output logic [P_NUM_REQ-1:0]           req_rdy,
    output logic [P_WIDTH-1:0]             out_data,
    output logic [P_ID_BITS-1:0]           out_id,
    output logic                           out_last,
    output logic                           out_vld,
    input  logic                           out_rdy,
    output logic [P_NUM_REQ-1:0]           grant,
    output logic                           busy
);

    localparam int unsigned CNT_W = $clog2(P_MAX_BURST) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_e;

    state_e                 state_q;
    logic [P_NUM_REQ-1:0]   grant_q;
    logic [P_ID_BITS-1:0]   id_q;
    logic [P_ID_BITS-1:0]   ptr_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [2*P_NUM_REQ-1:0] vld_dbl_c;
    logic [P_NUM_REQ-1:0]   vld_rot_c;
    logic                   pick_vld_c;
    logic [P_ID_BITS-1:0]   pick_id_c;
    logic [P_NUM_REQ-1:0]   pick_oh_c;
    logic [P_ID_BITS-1:0]   ptr_next_c;
    logic                   sel_last_c;
    logic                   cut_c;
    logic                   hs_c;

    // Rotate the valid vector so the search always starts at ptr_q; lowest set bit wins.
    always_comb begin
        vld_dbl_c  = {req_vld, req_vld} >> ptr_q;
        vld_rot_c  = vld_dbl_c[P_NUM_REQ-1:0];
        pick_vld_c = |req_vld;
        pick_id_c  = '0;
        for (int j = int'(P_NUM_REQ) - 1; j >= 0; j--) begin
            if (vld_rot_c[j]) begin
                if (32'(ptr_q) + 32'(j) >= P_NUM_REQ) begin
                    pick_id_c = P_ID_BITS'(32'(ptr_q) + 32'(j) - P_NUM_REQ);
                end else begin
                    pick_id_c = P_ID_BITS'(32'(ptr_q) + 32'(j));
                end
            end
        end
        pick_oh_c = '0;
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
            pick_oh_c[i] = (32'(pick_id_c) == i);
        end
    end

    // Data/handshake passthrough from the granted requester, muxed by the one-hot grant.
    always_comb begin
        out_vld    = 1'b0;
        out_data   = '0;
        req_rdy    = '0;
        sel_last_c = 1'b0;
        for (int unsigned i = 0; i < P_NUM_REQ; i++) begin
            if (grant_q[i]) begin
                out_vld    = out_vld | req_vld[i];
                out_data   = out_data | req_data[i*P_WIDTH +: P_WIDTH];
                req_rdy[i] = out_rdy;
                sel_last_c = sel_last_c | req_last[i];
            end
        end
        cut_c    = (cnt_q == CNT_W'(P_MAX_BURST - 1));
        out_last = out_vld & (sel_last_c | cut_c);
        hs_c     = out_vld & out_rdy;
    end

    assign ptr_next_c = (id_q == P_ID_BITS'(P_NUM_REQ - 1)) ? '0 : id_q + 1'b1;
    assign out_id     = id_q;
    assign grant      = grant_q;
    assign busy       = (state_q == S_BURST);

    // Grant lock for the whole packet; pointer advances past the winner when it ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_vld_c) begin
                        state_q <= S_BURST;
                        grant_q <= pick_oh_c;
                        id_q    <= pick_id_c;
                        cnt_q   <= '0;
                    end
                end
                S_BURST: begin
                    if (hs_c) begin
                        if (out_last) begin
                            state_q <= S_IDLE;
                            grant_q <= '0;
                            id_q    <= '0;
                            ptr_q   <= ptr_next_c;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (4 requesters, 8-bit data, 16-beat cut).
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned MB = 16;
    localparam int unsigned IB = 2;

    logic           clk;
    logic           rst;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_rdy;
    logic [W-1:0]   out_data;
    logic [IB-1:0]  out_id;
    logic           out_last;
    logic           out_vld;
    logic           out_rdy;
    logic [N-1:0]   grant;
    logic           busy;

    int n_pass  = 0;
    int n_total = 0;

    fifo_wr_arbiter #(
        .P_NUM_REQ  (N),
        .P_WIDTH    (W),
        .P_MAX_BURST(MB)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req_data(req_data),
        .req_vld (req_vld),
        .req_last(req_last),
        .req_rdy (req_rdy),
        .out_data(out_data),
        .out_id  (out_id),
        .out_last(out_last),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .grant   (grant),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_vld[i]         = v;
        req_data[i*W +: W] = d;
        req_last[i]        = l;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req_vld  = '0;
        req_last = '0;
        req_data = '0;
        out_rdy  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Requester 2 sends 20 beats; optionally requester 3 becomes valid at the forced cut.
    task automatic burst_cut(input bit with_r3);
        do_reset();
        out_rdy = 1'b1;
        set_req(2, 1'b1, 8'd1, 1'b0);
        tick();
        check("cut_grant", 32'(grant), 32'b0100);
        for (int b = 1; b <= 20; b++) begin
            set_req(2, 1'b1, 8'(b), b == 20);
            #1;
            check("cut_data", 32'(out_data), 32'(b));
            check("cut_last", 32'(out_last), 32'((b == 16) || (b == 20)));
            check("cut_id", 32'(out_id), 32'd2);
            if (b == 16) begin
                if (with_r3) set_req(3, 1'b1, 8'h33, 1'b1);
                tick();
                check("cut_idle", 32'(busy), 32'd0);
                tick();
                if (with_r3) begin
                    check("r3_grant", 32'(grant), 32'b1000);
                    check("r3_data", 32'(out_data), 32'h33);
                    check("r3_last", 32'(out_last), 32'd1);
                    check("r3_rdy", 32'(req_rdy), 32'b1000);
                    tick();
                    set_req(3, 1'b0, 8'h00, 1'b0);
                    check("r3_idle", 32'(busy), 32'd0);
                    tick();
                end
                check("regrant", 32'(grant), 32'b0100);
            end else begin
                tick();
            end
        end
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1;
        check("cut_end_busy", 32'(busy), 32'd0);
        check("cut_end_grant", 32'(grant), 32'd0);
    endtask

    initial begin
        logic [5:0] pat;
        int h;
        rst = 1'b1;
        do_reset();

        // Reset state
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_rdy", 32'(req_rdy), 32'd0);
        check("rst_id", 32'(out_id), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);

        // Requester 0 three-beat packet
        out_rdy = 1'b1;
        set_req(0, 1'b1, 8'hA1, 1'b0);
        #1;
        check("p0_idle_vld", 32'(out_vld), 32'd0);
        tick();
        check("p0_grant", 32'(grant), 32'b0001);
        for (int b = 0; b < 3; b++) begin
            set_req(0, 1'b1, 8'(8'hA1 + b), b == 2);
            #1;
            check("p0_data", 32'(out_data), 32'(8'hA1 + b));
            check("p0_last", 32'(out_last), 32'(b == 2));
            check("p0_id", 32'(out_id), 32'd0);
            tick();
        end
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        check("p0_done_busy", 32'(busy), 32'd0);
        check("p0_done_grant", 32'(grant), 32'd0);

        // All four requesters with 1-beat packets: strict rotation, one beat per 2 cycles
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_grant", 32'(grant), 32'(1 << (k % 4)));
            check("rr_id", 32'(out_id), 32'(k % 4));
            check("rr_data", 32'(out_data), 32'(8'h10 + (k % 4)));
            check("rr_last", 32'(out_last), 32'd1);
            check("rr_rdy", 32'(req_rdy), 32'(1 << (k % 4)));
            tick();
            check("rr_gap", 32'(busy), 32'd0);
        end
        req_vld = '0;

        // Forced cut at 16 beats, alone and with a competitor
        burst_cut(1'b0);
        burst_cut(1'b1);

        // Backpressure on requester 1: out_rdy 1,0,0,1,0,1
        do_reset();
        pat = 6'b101001;
        h = 0;
        set_req(1, 1'b1, 8'hB1, 1'b0);
        tick();
        check("bp_grant", 32'(grant), 32'b0010);
        for (int c = 0; c < 6; c++) begin
            out_rdy = pat[c];
            set_req(1, 1'b1, 8'(8'hB1 + h), h == 2);
            #1;
            check("bp_rdy", 32'(req_rdy), 32'({3'b000, pat[c]} << 1));
            check("bp_data", 32'(out_data), 32'(8'hB1 + h));
            check("bp_last", 32'(out_last), 32'(h == 2));
            if (pat[c]) h++;
            tick();
        end
        set_req(1, 1'b0, 8'h00, 1'b0);
        out_rdy = 1'b1;
        #1;
        check("bp_done_busy", 32'(busy), 32'd0);

        // Reset mid-packet from requester 3, then pointer restarts at 0
        do_reset();
        out_rdy = 1'b1;
        set_req(3, 1'b1, 8'h61, 1'b0);
        tick();
        check("mr_grant", 32'(grant), 32'b1000);
        for (int b = 1; b <= 5; b++) begin
            set_req(3, 1'b1, 8'(8'h60 + b), 1'b0);
            #1;
            check("mr_data", 32'(out_data), 32'(8'h60 + b));
            tick();
        end
        check("mr_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_grant0", 32'(grant), 32'd0);
        check("mr_busy0", 32'(busy), 32'd0);
        check("mr_rdy0", 32'(req_rdy), 32'd0);
        check("mr_vld0", 32'(out_vld), 32'd0);
        set_req(0, 1'b1, 8'h0A, 1'b1);
        tick();
        check("mr_regrant", 32'(grant), 32'b0001);
        check("mr_id", 32'(out_id), 32'd0);
        check("mr_data0", 32'(out_data), 32'h0A);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
